padd_operand_issue: RTL and testbench

// - Downstream of the bucket controller. Aligns point_mem / result_buffer data with the controller's registered bucket commands.
// - Supplies bucket write data, collects bucket read data, and forms the operand pair for the point adder (PADD).
// - Queues issued pairs in an output FIFO with valid/ready toward PADD, and back-pressures the point/result sources.

---
 rtl/padd_operand_issue_if.sv | 29 ++
 rtl/padd_operand_issue.sv | 188 ++++++++++++++++++
 tb/tb_padd_operand_issue.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/padd_operand_issue_if.sv
// PADD-facing operand stream: valid/ready handshake carrying the operand pair and bucket id.
interface padd_operand_issue_if #(
  parameter int unsigned WIDTH_ID   = 2,
  parameter int unsigned WIDTH_DATA = 384
);
  localparam int unsigned PT_W = 3 * WIDTH_DATA;

  logic                out_valid;
  logic                out_ready;
  logic [PT_W-1:0]     out_op0;
  logic [PT_W-1:0]     out_op1;
  logic [WIDTH_ID-1:0] out_id;

  modport master (
    output out_valid,
    output out_op0,
    output out_op1,
    output out_id,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_op0,
    input  out_op1,
    input  out_id,
    output out_ready
  );
endinterface

// File: rtl/padd_operand_issue.sv
// Aligns point/result sources with registered bucket commands, forms PADD operand pairs
// and queues them in a first-word-fall-through FIFO with source back-pressure.
module padd_operand_issue #(
  parameter int unsigned WIDTH_ID   = 2,
  parameter int unsigned WIDTH_DATA = 384,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pm_status,
  input  logic [WIDTH_ID-1:0]           id_i_pm,
  input  logic [3*WIDTH_DATA-1:0]       pm_data,
  input  logic                          rb_status,
  input  logic [WIDTH_ID-1:0]           id_i_rb,
  input  logic [3*WIDTH_DATA-1:0]       rb_data,
  input  logic                          r_en_bucket_a,
  input  logic                          r_en_bucket_b,
  input  logic [3*WIDTH_DATA-1:0]       rd_data_a,
  input  logic [3*WIDTH_DATA-1:0]       rd_data_b,
  output logic [3*WIDTH_DATA-1:0]       w_data_bucket_a,
  output logic [3*WIDTH_DATA-1:0]       w_data_bucket_b,
  padd_operand_issue_if.master          padd,
  output logic                          stall_o,
  output logic                          idle_o,
  output logic                          ovf_err,
  output logic [31:0]                   issue_cnt
);

  localparam int unsigned PT_W = 3 * WIDTH_DATA;
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = AW + 1;

  typedef struct packed {
    logic [WIDTH_ID-1:0] id;
    logic [PT_W-1:0]     op1;
    logic [PT_W-1:0]     op0;
  } entry_t;

  // Stage 1: source capture (cycle T)
  logic                r_s1_pm_v;
  logic                r_s1_rb_v;
  logic [WIDTH_ID-1:0] r_s1_id_pm;
  logic [WIDTH_ID-1:0] r_s1_id_rb;
  logic [PT_W-1:0]     r_s1_pm_data;
  logic [PT_W-1:0]     r_s1_rb_data;

  // Stage 2: stage-1 contents plus the controller's read commands (cycle T+1)
  logic                r_s2_pm_v;
  logic                r_s2_rb_v;
  logic                r_s2_ren_a;
  logic                r_s2_ren_b;
  logic [WIDTH_ID-1:0] r_s2_id_pm;
  logic [WIDTH_ID-1:0] r_s2_id_rb;
  logic [PT_W-1:0]     r_s2_pm_data;
  logic [PT_W-1:0]     r_s2_rb_data;

  // FIFO state
  entry_t              r_mem [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic                r_ovf;
  logic [31:0]         r_issue_cnt;

  logic                w_push;
  logic                w_push_acc;
  logic                w_pop;
  logic                w_full;
  logic                w_nonempty;
  entry_t              w_entry;
  entry_t              w_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_pm_v    <= 1'b0;
      r_s1_rb_v    <= 1'b0;
      r_s1_id_pm   <= '0;
      r_s1_id_rb   <= '0;
      r_s1_pm_data <= '0;
      r_s1_rb_data <= '0;
    end else begin
      r_s1_pm_v    <= pm_status;
      r_s1_rb_v    <= rb_status;
      r_s1_id_pm   <= id_i_pm;
      r_s1_id_rb   <= id_i_rb;
      r_s1_pm_data <= pm_data;
      r_s1_rb_data <= rb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_pm_v    <= 1'b0;
      r_s2_rb_v    <= 1'b0;
      r_s2_ren_a   <= 1'b0;
      r_s2_ren_b   <= 1'b0;
      r_s2_id_pm   <= '0;
      r_s2_id_rb   <= '0;
      r_s2_pm_data <= '0;
      r_s2_rb_data <= '0;
    end else begin
      r_s2_pm_v    <= r_s1_pm_v;
      r_s2_rb_v    <= r_s1_rb_v;
      r_s2_ren_a   <= r_en_bucket_a;
      r_s2_ren_b   <= r_en_bucket_b;
      r_s2_id_pm   <= r_s1_id_pm;
      r_s2_id_rb   <= r_s1_id_rb;
      r_s2_pm_data <= r_s1_pm_data;
      r_s2_rb_data <= r_s1_rb_data;
    end
  end

  assign w_data_bucket_a = r_s1_pm_data;
  assign w_data_bucket_b = r_s1_rb_data;

  // Pair selection at T+2: bucket reads win over a direct point/result match
  always_comb begin
    w_push  = 1'b0;
    w_entry = '0;
    if (r_s2_ren_a) begin
      w_push      = 1'b1;
      w_entry.op0 = r_s2_pm_data;
      w_entry.op1 = rd_data_a;
      w_entry.id  = r_s2_id_pm;
    end else if (r_s2_ren_b) begin
      w_push      = 1'b1;
      w_entry.op0 = r_s2_rb_data;
      w_entry.op1 = rd_data_b;
      w_entry.id  = r_s2_id_rb;
    end else if (r_s2_pm_v && r_s2_rb_v && (r_s2_id_pm == r_s2_id_rb)) begin
      w_push      = 1'b1;
      w_entry.op0 = r_s2_pm_data;
      w_entry.op1 = r_s2_rb_data;
      w_entry.id  = r_s2_id_pm;
    end
  end

  assign w_nonempty = (r_count != '0);
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_pop      = w_nonempty && padd.out_ready;
  // A pop frees the head slot this cycle, so a full FIFO still takes a simultaneous push
  assign w_push_acc = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push_acc) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_issue_cnt <= '0;
    end else begin
      if (w_push_acc) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + AW'(1);
        r_issue_cnt <= r_issue_cnt + 32'd1;
      end
      if (w_push_acc && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push_acc) begin
        r_count <= r_count - CW'(1);
      end
      if (w_push && !w_push_acc) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign w_head         = r_mem[r_rd_ptr];
  assign padd.out_valid = w_nonempty;
  assign padd.out_op0   = w_nonempty ? w_head.op0 : '0;
  assign padd.out_op1   = w_nonempty ? w_head.op1 : '0;
  assign padd.out_id    = w_nonempty ? w_head.id  : '0;

  // Threshold leaves room for the two pipeline stages already in flight plus one spare
  assign stall_o   = (r_count >= CW'(DEPTH - 3));
  assign idle_o    = !(r_s1_pm_v || r_s1_rb_v) && !(r_s2_pm_v || r_s2_rb_v) && !w_nonempty;
  assign ovf_err   = r_ovf;
  assign issue_cnt = r_issue_cnt;

endmodule

// File: tb/tb_padd_operand_issue.sv
// Directed bench for padd_operand_issue: bucket/result hits, direct pairs, priority,
// write-data alignment, back-pressure, overflow and mid-stream reset.
module tb_padd_operand_issue;

  localparam int unsigned WID  = 2;
  localparam int unsigned WD   = 384;
  localparam int unsigned PT_W = 3 * WD;

  localparam logic [PT_W-1:0] P1     = {384'h11, 384'h12, 384'h13};
  localparam logic [PT_W-1:0] B1     = {384'hB1, 384'hB2, 384'hB3};
  localparam logic [PT_W-1:0] Q1     = {384'h5151, 384'h5252, 384'h5353};
  localparam logic [PT_W-1:0] R1     = {384'h7001, 384'h7002, 384'h7003};
  localparam logic [PT_W-1:0] P2     = {384'h21, 384'h22, 384'h23};
  localparam logic [PT_W-1:0] R2     = {384'h2001, 384'h2002, 384'h2003};
  localparam logic [PT_W-1:0] R3     = {384'h3001, 384'h3002, 384'h3003};
  localparam logic [PT_W-1:0] C3     = {384'hC1, 384'hC2, 384'hC3};
  localparam logic [PT_W-1:0] P4     = {384'h41, 384'h42, 384'h43};
  localparam logic [PT_W-1:0] R4     = {384'h4001, 384'h4002, 384'h4003};
  localparam logic [PT_W-1:0] B4     = {384'hB41, 384'hB42, 384'hB43};
  localparam logic [PT_W-1:0] PBASE  = {384'hE1, 384'hE2, 384'hE00};
  localparam logic [PT_W-1:0] R5     = {384'h5001, 384'h5002, 384'h5003};
  localparam logic [PT_W-1:0] P6     = {384'h61, 384'h62, 384'h63};
  localparam logic [PT_W-1:0] P7     = {384'h71, 384'h72, 384'h73};
  localparam logic [PT_W-1:0] JUNK_A = {384'hDEAD, 384'hBEEF, 384'hAAAA};
  localparam logic [PT_W-1:0] JUNK_B = {384'hFACE, 384'hCAFE, 384'hBBBB};

  logic            clk;
  logic            rst_n;
  logic            pm_status, rb_status;
  logic [WID-1:0]  id_i_pm, id_i_rb;
  logic [PT_W-1:0] pm_data, rb_data;
  logic            r_en_bucket_a, r_en_bucket_b;
  logic [PT_W-1:0] rd_data_a, rd_data_b;
  logic [PT_W-1:0] w_data_bucket_a, w_data_bucket_b;
  logic            stall_o, idle_o, ovf_err;
  logic [31:0]     issue_cnt;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned n_src;

  padd_operand_issue_if #(.WIDTH_ID(WID), .WIDTH_DATA(WD)) u_if ();

  padd_operand_issue #(.WIDTH_ID(WID), .WIDTH_DATA(WD), .DEPTH(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pm_status       (pm_status),
    .id_i_pm         (id_i_pm),
    .pm_data         (pm_data),
    .rb_status       (rb_status),
    .id_i_rb         (id_i_rb),
    .rb_data         (rb_data),
    .r_en_bucket_a   (r_en_bucket_a),
    .r_en_bucket_b   (r_en_bucket_b),
    .rd_data_a       (rd_data_a),
    .rd_data_b       (rd_data_b),
    .w_data_bucket_a (w_data_bucket_a),
    .w_data_bucket_b (w_data_bucket_b),
    .padd            (u_if.master),
    .stall_o         (stall_o),
    .idle_o          (idle_o),
    .ovf_err         (ovf_err),
    .issue_cnt       (issue_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation time limit reached");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [PT_W-1:0] obs, input logic [PT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs[95:0], exp[95:0]);
    end
  endtask

  task automatic src_idle();
    pm_status     = 1'b0;
    rb_status     = 1'b0;
    r_en_bucket_a = 1'b0;
    r_en_bucket_b = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    src_idle();
    id_i_pm = '0; id_i_rb = '0;
    pm_data = '0; rb_data = '0;
    rd_data_a = JUNK_A; rd_data_b = JUNK_B;
    u_if.out_ready = 1'b0;
    step(); step();

    // reset state
    chk("rst_out_valid", PT_W'(u_if.out_valid), '0);
    chk("rst_idle", PT_W'(idle_o), PT_W'(1));
    chk("rst_stall", PT_W'(stall_o), '0);
    chk("rst_wdata_a", w_data_bucket_a, '0);
    chk("rst_wdata_b", w_data_bucket_b, '0);
    chk("rst_op0", u_if.out_op0, '0);
    chk("rst_id", PT_W'(u_if.out_id), '0);
    chk("rst_ovf", PT_W'(ovf_err), '0);
    chk("rst_issue_cnt", PT_W'(issue_cnt), '0);
    rst_n = 1'b1;
    step();

    // bucket hit on port A
    u_if.out_ready = 1'b1;
    pm_status = 1'b1; id_i_pm = 2'd2; pm_data = P1;
    step();
    src_idle(); r_en_bucket_a = 1'b1;
    chk("hitA_wdata_a", w_data_bucket_a, P1);
    step();
    r_en_bucket_a = 1'b0; rd_data_a = B1;
    chk("hitA_no_early_valid", PT_W'(u_if.out_valid), '0);
    step();
    rd_data_a = JUNK_A;
    chk("hitA_valid", PT_W'(u_if.out_valid), PT_W'(1));
    chk("hitA_op0", u_if.out_op0, P1);
    chk("hitA_op1", u_if.out_op1, B1);
    chk("hitA_id", PT_W'(u_if.out_id), PT_W'(2));
    step();
    chk("hitA_issue_cnt", PT_W'(issue_cnt), PT_W'(1));
    chk("hitA_drained", PT_W'(u_if.out_valid), '0);

    // write-data alignment with no read and mismatched ids: nothing issues
    pm_status = 1'b1; id_i_pm = 2'd0; pm_data = Q1;
    rb_status = 1'b1; id_i_rb = 2'd1; rb_data = R1;
    step();
    src_idle();
    chk("align_wdata_a", w_data_bucket_a, Q1);
    chk("align_wdata_b", w_data_bucket_b, R1);
    step(); step();
    chk("align_no_push", PT_W'(u_if.out_valid), '0);
    chk("align_idle", PT_W'(idle_o), PT_W'(1));

    // direct pair, same id, no bucket reads
    pm_status = 1'b1; id_i_pm = 2'd1; pm_data = P2;
    rb_status = 1'b1; id_i_rb = 2'd1; rb_data = R2;
    step();
    src_idle();
    step(); step();
    chk("direct_valid", PT_W'(u_if.out_valid), PT_W'(1));
    chk("direct_op0", u_if.out_op0, P2);
    chk("direct_op1", u_if.out_op1, R2);
    chk("direct_id", PT_W'(u_if.out_id), PT_W'(1));
    step();
    chk("direct_issue_cnt", PT_W'(issue_cnt), PT_W'(2));

    // result hit on port B
    rb_status = 1'b1; id_i_rb = 2'd3; rb_data = R3;
    step();
    src_idle(); r_en_bucket_b = 1'b1;
    chk("hitB_wdata_b", w_data_bucket_b, R3);
    step();
    r_en_bucket_b = 1'b0; rd_data_b = C3;
    step();
    rd_data_b = JUNK_B;
    chk("hitB_op0", u_if.out_op0, R3);
    chk("hitB_op1", u_if.out_op1, C3);
    chk("hitB_id", PT_W'(u_if.out_id), PT_W'(3));
    step();
    chk("hitB_issue_cnt", PT_W'(issue_cnt), PT_W'(3));

    // port A read outranks port B read and a matching direct pair
    pm_status = 1'b1; id_i_pm = 2'd0; pm_data = P4;
    rb_status = 1'b1; id_i_rb = 2'd0; rb_data = R4;
    step();
    src_idle(); r_en_bucket_a = 1'b1; r_en_bucket_b = 1'b1;
    step();
    src_idle(); rd_data_a = B4;
    step();
    rd_data_a = JUNK_A;
    chk("prio_op0", u_if.out_op0, P4);
    chk("prio_op1", u_if.out_op1, B4);
    chk("prio_id", PT_W'(u_if.out_id), '0);
    step();
    chk("prio_single_push", PT_W'(u_if.out_valid), '0);
    chk("prio_issue_cnt", PT_W'(issue_cnt), PT_W'(4));

    // back-pressure: one direct pair per cycle while stall_o is low
    u_if.out_ready = 1'b0;
    n_src = 0;
    rb_data = R5; id_i_pm = 2'd1; id_i_rb = 2'd1;
    for (int c = 0; c < 20; c++) begin
      if (!stall_o) begin
        pm_status = 1'b1; rb_status = 1'b1;
        pm_data = PBASE + PT_W'(n_src);
        n_src++;
      end else begin
        src_idle();
      end
      step();
    end
    src_idle();
    chk("bp_sources_issued", PT_W'(n_src), PT_W'(7));
    chk("bp_stall", PT_W'(stall_o), PT_W'(1));
    chk("bp_no_ovf", PT_W'(ovf_err), '0);
    chk("bp_head_op0", u_if.out_op0, PBASE);

    // fill the last slot, then push once more into a full FIFO
    pm_status = 1'b1; rb_status = 1'b1; pm_data = P6;
    step(); src_idle(); step(); step();
    chk("full_no_ovf", PT_W'(ovf_err), '0);
    pm_status = 1'b1; rb_status = 1'b1; pm_data = P7;
    step(); src_idle(); step(); step();
    chk("full_ovf", PT_W'(ovf_err), PT_W'(1));

    // drain: order preserved, dropped entry absent
    u_if.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain_op0_%0d", i), u_if.out_op0, (i < 7) ? PBASE + PT_W'(i) : P6);
      step();
    end
    chk("drain_empty", PT_W'(u_if.out_valid), '0);
    chk("drain_issue_cnt", PT_W'(issue_cnt), PT_W'(12));
    chk("drain_ovf_sticky", PT_W'(ovf_err), PT_W'(1));

    // reset with three pairs queued
    u_if.out_ready = 1'b0;
    pm_status = 1'b1; rb_status = 1'b1; pm_data = P2; rb_data = R2;
    step(); step(); step();
    src_idle();
    step(); step(); step();
    chk("pre_rst_valid", PT_W'(u_if.out_valid), PT_W'(1));
    #2 rst_n = 1'b0;
    step();
    chk("mid_rst_valid", PT_W'(u_if.out_valid), '0);
    chk("mid_rst_idle", PT_W'(idle_o), PT_W'(1));
    chk("mid_rst_issue_cnt", PT_W'(issue_cnt), '0);
    chk("mid_rst_ovf", PT_W'(ovf_err), '0);
    rst_n = 1'b1;
    step();
    chk("post_rst_valid", PT_W'(u_if.out_valid), '0);
    chk("post_rst_stall", PT_W'(stall_o), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
